// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the two-port register-access arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [1:0] ADDR_FIFO = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_MEM  = 2'd2;

  // Write data bit that clears the FIFO when written to the STAT register.
  localparam int STAT_CLR_BIT = 4;

  // A transaction is refused when it targets the unmapped address, writes the
  // read-only MEM window, or would overflow/underflow the downstream FIFO.
  function automatic logic txn_illegal(input logic [1:0] addr,
                                       input logic       write,
                                       input logic       at_full,
                                       input logic       at_empty);
    logic bad;
    bad = 1'b0;
    if (addr == 2'd3)                         bad = 1'b1;
    if (write && (addr == ADDR_MEM))          bad = 1'b1;
    if (write && (addr == ADDR_FIFO) && at_full)   bad = 1'b1;
    if (!write && (addr == ADDR_FIFO) && at_empty) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. The requester not served last has priority;
// priority only moves when the owner accepts the grant (advance).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio;
  logic other;

  assign other = ~prio;

  // One-hot pick: the priority holder wins if requesting, else the other one.
  always_comb begin
    grant = 2'b00;
    if (req[prio])
      grant[prio] = 1'b1;
    else if (req[other])
      grant[other] = 1'b1;
  end

  // After serving requester 0 priority goes to 1, and vice versa.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prio <= 1'b0;
    else if (advance && (grant != 2'b00))
      prio <= grant[0];
  end

endmodule

// File: rtl/fifo_port_arbiter.sv
// Arbitrates two requesters onto a single register port and keeps a shadow
// occupancy count of the downstream FIFO so illegal accesses never reach it.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for a request; winner gets req_ready, fields latched
//   ST_ISSUE | one-cycle bus strobe (suppressed for illegal transactions)
//   ST_WAIT  | strobes low, address held, read data captured at end
//   ST_RESP  | one-cycle rsp_valid to the latched requester
module fifo_port_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  parameter  int NUM_REQ    = 2,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][1:0] req_addr,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ-1:0][7:0] req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [7:0]              rsp_rdata,
  output logic                    rsp_err,
  output logic                    bus_enable,
  output logic                    bus_write,
  output logic                    bus_read,
  output logic [1:0]              bus_addr,
  output logic [7:0]              bus_wdata,
  input  logic [7:0]              bus_rdata,
  output logic [LVL_W-1:0]        fifo_level
);

  arb_state_e state_q, state_d;

  logic [1:0] grant;
  logic       win_idx;
  logic       take;

  logic       lat_idx;
  logic [1:0] lat_addr;
  logic       lat_write;
  logic [7:0] lat_wdata;
  logic       err_q;
  logic [7:0] rdata_q;

  logic       at_full;
  logic       at_empty;
  logic       txn_err;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (take),
    .grant   (grant)
  );

  assign take    = (state_q == ST_IDLE) && (grant != 2'b00);
  assign win_idx = grant[1];

  assign at_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign at_empty = (fifo_level == '0);

  // Level does not move between IDLE and the end of ISSUE, so the check made
  // here from the latch is the one that applies to the strobe.
  assign txn_err = txn_illegal(lat_addr, lat_write, at_full, at_empty);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next state and all port outputs; req_ready is masked while rst is high
  // because the arbiter's grant is combinational on req_valid.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_rdata  = 8'h00;
    rsp_err    = 1'b0;
    bus_enable = 1'b0;
    bus_write  = 1'b0;
    bus_read   = 1'b0;
    bus_addr   = 2'b00;
    bus_wdata  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (!rst)
          req_ready = grant;
        if (take)
          state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!txn_err) begin
          bus_enable = 1'b1;
          bus_write  = lat_write;
          bus_read   = ~lat_write;
          bus_addr   = lat_addr;
          bus_wdata  = lat_wdata;
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        bus_addr = lat_addr;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[lat_idx] = 1'b1;
        rsp_rdata          = rdata_q;
        rsp_err            = err_q;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the winner's request on the grant cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_idx   <= 1'b0;
      lat_addr  <= 2'b00;
      lat_write <= 1'b0;
      lat_wdata <= 8'h00;
    end else if (take) begin
      lat_idx   <= win_idx;
      lat_addr  <= req_addr[win_idx];
      lat_write <= req_write[win_idx];
      lat_wdata <= req_wdata[win_idx];
    end
  end

  // Error is frozen at the end of ISSUE since the level may change there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (state_q == ST_ISSUE)
      err_q <= txn_err;
  end

  // Read data sampled at the end of WAIT; zero for writes and errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata_q <= 8'h00;
    else if (state_q == ST_WAIT)
      rdata_q <= (!err_q && !lat_write) ? bus_rdata : 8'h00;
  end

  // Shadow FIFO occupancy, updated only by legal transactions at end of ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_level <= '0;
    end else if ((state_q == ST_ISSUE) && !txn_err) begin
      if (lat_addr == ADDR_FIFO) begin
        if (lat_write)
          fifo_level <= fifo_level + LVL_W'(1);
        else
          fifo_level <= fifo_level - LVL_W'(1);
      end else if ((lat_addr == ADDR_STAT) && lat_write && lat_wdata[STAT_CLR_BIT]) begin
        fifo_level <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Self-checking bench for fifo_port_arbiter: directed scenarios plus random
// two-requester traffic against a transaction-level reference model.
module tb_fifo_port_arbiter;

  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0][1:0]  req_addr;
  logic [1:0]       req_write;
  logic [1:0][7:0]  req_wdata;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [7:0]       rsp_rdata;
  logic             rsp_err;
  logic             bus_enable;
  logic             bus_write;
  logic             bus_read;
  logic [1:0]       bus_addr;
  logic [7:0]       bus_wdata;
  logic [7:0]       bus_rdata;
  logic [LVL_W-1:0] fifo_level;

  fifo_port_arbiter #(.FIFO_DEPTH(DEPTH), .NUM_REQ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus_enable (bus_enable),
    .bus_write  (bus_write),
    .bus_read   (bus_read),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-port device: a real byte FIFO at addr 0, count at addr 1,
  // fixed pattern at addr 2.
  logic [7:0] dev_q[$];
  logic [7:0] dev_head;
  logic [7:0] dev_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dev_q.delete();
      dev_head <= 8'h00;
      dev_cnt  <= 8'h00;
    end else begin
      if (bus_enable) begin
        if (bus_write && bus_addr == 2'd0)
          dev_q.push_back(bus_wdata);
        else if (bus_read && bus_addr == 2'd0 && dev_q.size() > 0)
          dev_head <= dev_q.pop_front();
        else if (bus_write && bus_addr == 2'd1 && bus_wdata[4])
          dev_q.delete();
      end
      dev_cnt <= 8'(dev_q.size());
    end
  end

  always_comb begin
    case (bus_addr)
      2'd0:    bus_rdata = dev_head;
      2'd1:    bus_rdata = dev_cnt;
      2'd2:    bus_rdata = 8'h5C;
      default: bus_rdata = 8'hEE;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int         m_level;
  int         m_prio;
  logic [7:0] m_q[$];

  // Pending requests held by the two requesters.
  logic       pend_v[2];
  logic [1:0] pend_a[2];
  logic       pend_w[2];
  logic [7:0] pend_d[2];
  int         last_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = pend_v[i];
      req_addr[i]  = pend_a[i];
      req_write[i] = pend_w[i];
      req_wdata[i] = pend_d[i];
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] a, input logic w, input logic [7:0] d);
    pend_v[i] = 1'b1;
    pend_a[i] = a;
    pend_w[i] = w;
    pend_d[i] = d;
  endtask

  task automatic model_reset();
    m_level = 0;
    m_prio  = 0;
    m_q.delete();
    for (int i = 0; i < 2; i++) pend_v[i] = 1'b0;
  endtask

  // Called at a falling edge while the DUT is idle; runs one full transaction.
  task automatic run_txn();
    int         w;
    logic [1:0] a;
    logic       wr;
    logic [7:0] d;
    logic       e;
    logic [7:0] rd;
    drive_reqs();
    #1;
    w = (pend_v[0] && pend_v[1]) ? m_prio : (pend_v[1] ? 1 : 0);
    chk("grant", 32'(req_ready), 32'(1) << w);
    m_prio = 1 - w;
    a  = pend_a[w];
    wr = pend_w[w];
    d  = pend_d[w];
    pend_v[w] = 1'b0;

    e = (a == 2'd3) || (wr && a == 2'd2) ||
        (wr && a == 2'd0 && m_level == DEPTH) || (!wr && a == 2'd0 && m_level == 0);
    rd = 8'h00;
    if (!e) begin
      if (a == 2'd0) begin
        if (wr) begin
          m_q.push_back(d);
          m_level++;
        end else begin
          rd = m_q.pop_front();
          m_level--;
        end
      end else if (a == 2'd1) begin
        if (wr && d[4]) begin
          m_level = 0;
          m_q.delete();
        end else if (!wr) begin
          rd = 8'(m_level);
        end
      end else if (!wr) begin
        rd = 8'h5C;
      end
    end

    @(negedge clk);
    drive_reqs();
    #1;
    chk("issue_ready", 32'(req_ready), 0);
    chk("issue_en", 32'(bus_enable), 32'(!e));
    chk("issue_wr", 32'(bus_write), 32'(!e && wr));
    chk("issue_rd", 32'(bus_read), 32'(!e && !wr));
    if (!e) begin
      chk("issue_addr", 32'(bus_addr), 32'(a));
      if (wr) chk("issue_wdata", 32'(bus_wdata), 32'(d));
    end

    @(negedge clk);
    #1;
    chk("wait_strobes", {bus_enable, bus_write, bus_read}, 0);
    chk("wait_addr", 32'(bus_addr), e ? 32'(bus_addr) : 32'(a));
    chk("wait_ready", 32'(req_ready), 0);
    chk("wait_rsp", 32'(rsp_valid), 0);

    @(negedge clk);
    #1;
    chk("resp_valid", 32'(rsp_valid), 32'(1) << w);
    chk("resp_err", 32'(rsp_err), 32'(e));
    chk("resp_rdata", 32'(rsp_rdata), 32'(rd));
    chk("resp_level", 32'(fifo_level), 32'(m_level));
    chk("resp_ready", 32'(req_ready), 0);

    @(negedge clk);
    last_w = w;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_bus"}, {bus_enable, bus_write, bus_read, bus_addr, bus_wdata}, 0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    drive_reqs();
    #1;
    check_quiet("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    drive_reqs();
    @(negedge clk);
    do_reset();

    // Contention straight after reset: grants alternate starting at 0.
    set_req(0, 2'd0, 1'b1, 8'h10);
    set_req(1, 2'd0, 1'b1, 8'h20);
    for (int k = 0; k < 4; k++) begin
      run_txn();
      chk("contend_order", 32'(last_w), 32'(k % 2));
      set_req(last_w, 2'd0, 1'b1, 8'(8'h30 + k));
    end
    model_reset();
    drive_reqs();
    do_reset();

    // Single write.
    set_req(0, 2'd0, 1'b1, 8'hA5);
    run_txn();
    chk("single_level", 32'(fifo_level), 1);
    do_reset();

    // Fill to full, overflow attempt, drain in order, underflow attempt.
    for (int k = 0; k < DEPTH; k++) begin
      set_req(k % 2, 2'd0, 1'b1, 8'($urandom));
      run_txn();
    end
    chk("full_level", 32'(fifo_level), DEPTH);
    set_req(0, 2'd0, 1'b1, 8'h77);
    run_txn();
    for (int k = 0; k < DEPTH; k++) begin
      set_req(1, 2'd0, 1'b0, 8'h00);
      run_txn();
    end
    set_req(1, 2'd0, 1'b0, 8'h00);
    run_txn();
    chk("empty_level", 32'(fifo_level), 0);

    // Clear via STAT, then illegal and benign register accesses.
    for (int k = 0; k < 5; k++) begin
      set_req(0, 2'd0, 1'b1, 8'(k + 1));
      run_txn();
    end
    set_req(1, 2'd1, 1'b1, 8'h10);
    run_txn();
    chk("clear_level", 32'(fifo_level), 0);
    set_req(0, 2'd2, 1'b1, 8'h99);
    run_txn();
    set_req(0, 2'd3, 1'b0, 8'h00);
    run_txn();
    set_req(1, 2'd3, 1'b1, 8'h42);
    run_txn();
    set_req(0, 2'd2, 1'b0, 8'h00);
    run_txn();
    set_req(0, 2'd0, 1'b1, 8'h3C);
    run_txn();
    set_req(1, 2'd1, 1'b1, 8'h01);
    run_txn();
    set_req(0, 2'd1, 1'b0, 8'h00);
    run_txn();

    // Random traffic from both requesters, pending requests held until granted.
    for (int k = 0; k < 80; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend_v[i] && ($urandom_range(0, 1) == 1)) begin
          if ($urandom_range(0, 3) != 0)
            set_req(i, 2'd0, 1'($urandom_range(0, 1)), 8'($urandom));
          else
            set_req(i, 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
        end
      end
      if (!pend_v[0] && !pend_v[1])
        set_req(0, 2'd0, 1'b1, 8'($urandom));
      run_txn();
    end
    for (int i = 0; i < 2; i++) pend_v[i] = 1'b0;
    drive_reqs();

    // Reset during WAIT of a read drops the transaction.
    do_reset();
    set_req(0, 2'd0, 1'b1, 8'h5A);
    run_txn();
    set_req(0, 2'd0, 1'b0, 8'h00);
    drive_reqs();
    #1;
    chk("rst_pre_grant", 32'(req_ready), 1);
    @(negedge clk);
    pend_v[0] = 1'b0;
    drive_reqs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_quiet("rst_wait");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_quiet("rst_hold");
    end
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    set_req(1, 2'd0, 1'b1, 8'h11);
    set_req(0, 2'd0, 1'b1, 8'h22);
    run_txn();
    chk("post_rst_first", 32'(last_w), 0);
    run_txn();
    chk("post_rst_second", 32'(last_w), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
